// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer_if
// Description : Request/response handshakes plus the ALU operand/result bus
//               of the ALU operation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_a;
    logic [3:0] req_b;

    logic [1:0] alu_s;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] y_add;
    logic [3:0] y_sub;
    logic [3:0] y_and;
    logic       carry_add;
    logic       carry_sub;
    logic       agb;
    logic       aeb;
    logic       alb;

    logic       res_valid;
    logic       res_ready;
    logic [1:0] res_op;
    logic [3:0] res_data;
    logic       res_carry;
    logic [2:0] res_flags;
    logic       busy;
    logic [7:0] txn_count;

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready,
        output alu_s, alu_a, alu_b,
        input  y_add, y_sub, y_and, carry_add, carry_sub, agb, aeb, alb,
        output res_valid, res_op, res_data, res_carry, res_flags,
        input  res_ready,
        output busy, txn_count
    );

    // Requester / ALU / consumer side
    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready,
        input  alu_s, alu_a, alu_b,
        output y_add, y_sub, y_and, carry_add, carry_sub, agb, aeb, alb,
        input  res_valid, res_op, res_data, res_carry, res_flags,
        output res_ready,
        input  busy, txn_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Clocked front-end for a combinational 4-bit ALU: launches one
//               operation, waits SETTLE_CYCLES edges, returns a response.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2   // legal 1..15
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    alu_op_sequencer_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [3:0] C_LAST_CNT = 4'(SETTLE_CYCLES - 1);

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_alu_s;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic       r_res_valid;
    logic [1:0] r_res_op;
    logic [3:0] r_res_data;
    logic       r_res_carry;
    logic [2:0] r_res_flags;
    logic [7:0] r_txn_count;

    logic [3:0] w_cap_data;
    logic       w_cap_carry;
    logic [2:0] w_cap_flags;

    // Result selection follows the launched select, not the live request
    always_comb begin
        w_cap_data  = 4'd0;
        w_cap_carry = 1'b0;
        w_cap_flags = 3'b000;
        case (r_alu_s)
            2'b00: begin
                w_cap_data  = bus.y_add;
                w_cap_carry = bus.carry_add;
            end
            2'b01: begin
                w_cap_data  = bus.y_sub;
                w_cap_carry = bus.carry_sub;
            end
            2'b10: w_cap_flags = {bus.agb, bus.aeb, bus.alb};
            default: w_cap_data = bus.y_and;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_alu_s     <= 2'd0;
            r_alu_a     <= 4'd0;
            r_alu_b     <= 4'd0;
            r_res_valid <= 1'b0;
            r_res_op    <= 2'd0;
            r_res_data  <= 4'd0;
            r_res_carry <= 1'b0;
            r_res_flags <= 3'd0;
            r_txn_count <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_alu_s <= bus.req_op;
                        r_alu_a <= bus.req_a;
                        r_alu_b <= bus.req_b;
                        r_cnt   <= 4'd0;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == C_LAST_CNT) begin
                        r_res_valid <= 1'b1;
                        r_res_op    <= r_alu_s;
                        r_res_data  <= w_cap_data;
                        r_res_carry <= w_cap_carry;
                        r_res_flags <= w_cap_flags;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_txn_count <= r_txn_count + 8'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.alu_s     = r_alu_s;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.res_valid = r_res_valid;
    assign bus.res_op    = r_res_op;
    assign bus.res_data  = r_res_data;
    assign bus.res_carry = r_res_carry;
    assign bus.res_flags = r_res_flags;
    assign bus.txn_count = r_txn_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Self-checking bench for alu_op_sequencer with an ALU model and
//               an arithmetic reference for responses and transaction count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam int SETTLE = 2;
    localparam int PERIOD = SETTLE + 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_count;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: subtraction as A + ~B + 1 with its carry-out
    logic [4:0] w_sum;
    logic [4:0] w_dif;
    assign w_sum         = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    assign w_dif         = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1;
    assign bus.y_add     = w_sum[3:0];
    assign bus.carry_add = w_sum[4];
    assign bus.y_sub     = w_dif[3:0];
    assign bus.carry_sub = w_dif[4];
    assign bus.y_and     = bus.alu_a & bus.alu_b;
    assign bus.agb       = bus.alu_a > bus.alu_b;
    assign bus.aeb       = bus.alu_a == bus.alu_b;
    assign bus.alb       = bus.alu_a < bus.alu_b;

    function automatic int m_data(input int op, input int a, input int b);
        case (op)
            0: return (a + b) % 16;
            1: return (a + 16 - b) % 16;
            2: return 0;
            default: return a & b;
        endcase
    endfunction

    function automatic int m_carry(input int op, input int a, input int b);
        if (op == 0) return (a + b > 15) ? 1 : 0;
        if (op == 1) return (a >= b) ? 1 : 0;
        return 0;
    endfunction

    function automatic int m_flags(input int op, input int a, input int b);
        if (op != 2) return 0;
        return ((a > b) ? 4 : 0) + ((a == b) ? 2 : 0) + ((a < b) ? 1 : 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE, with 'stall' cycles of response backpressure
    task automatic do_txn(input int op, input int a, input int b, input int stall);
        chk("idle_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'(op);
        bus.req_a     = 4'(a);
        bus.req_b     = 4'(b);
        step();
        bus.req_valid = 1'b0;
        bus.res_ready = (stall == 0);
        chk("launch_busy", 32'(bus.busy), 32'd1);
        chk("launch_s",    32'(bus.alu_s), 32'(op));
        chk("launch_a",    32'(bus.alu_a), 32'(a));
        chk("launch_b",    32'(bus.alu_b), 32'(b));
        chk("launch_rv",   32'(bus.res_valid), 32'd0);
        for (int i = 1; i < SETTLE; i++) begin
            step();
            chk("settle_rv", 32'(bus.res_valid), 32'd0);
        end
        step();
        chk("resp_valid", 32'(bus.res_valid), 32'd1);
        chk("resp_op",    32'(bus.res_op), 32'(op));
        chk("resp_data",  32'(bus.res_data), 32'(m_data(op, a, b)));
        chk("resp_carry", 32'(bus.res_carry), 32'(m_carry(op, a, b)));
        chk("resp_flags", 32'(bus.res_flags), 32'(m_flags(op, a, b)));
        chk("resp_rdy",   32'(bus.req_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = 2'(op + 1);
            bus.req_a     = 4'(a + 5);
            bus.req_b     = 4'(b + 3);
            step();
            chk("stall_rv",   32'(bus.res_valid), 32'd1);
            chk("stall_data", 32'(bus.res_data), 32'(m_data(op, a, b)));
            chk("stall_op",   32'(bus.res_op), 32'(op));
            chk("stall_rdy",  32'(bus.req_ready), 32'd0);
            chk("stall_busy", 32'(bus.busy), 32'd1);
            chk("stall_a",    32'(bus.alu_a), 32'(a));
            chk("stall_cnt",  32'(bus.txn_count), 32'(exp_count));
        end
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
        step();
        exp_count = (exp_count + 1) % 256;
        chk("hs_rv",   32'(bus.res_valid), 32'd0);
        chk("hs_rdy",  32'(bus.req_ready), 32'd1);
        chk("hs_busy", 32'(bus.busy), 32'd0);
        chk("hs_cnt",  32'(bus.txn_count), 32'(exp_count));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_count     = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_a     = 4'd0;
        bus.req_b     = 4'd0;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset values
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_rv",    32'(bus.res_valid), 32'd0);
        chk("rst_alu",   32'({bus.alu_s, bus.alu_a, bus.alu_b}), 32'd0);
        chk("rst_res",   32'({bus.res_op, bus.res_data, bus.res_carry, bus.res_flags}), 32'd0);
        chk("rst_cnt",   32'(bus.txn_count), 32'd0);

        // Asynchronous reset pulsed mid-SETTLE
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd1;
        bus.req_a     = 4'd9;
        bus.req_b     = 4'd4;
        step();
        bus.req_valid = 1'b0;
        chk("mid_busy", 32'(bus.busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy",  32'(bus.busy), 32'd0);
        chk("arst_ready", 32'(bus.req_ready), 32'd1);
        chk("arst_alu",   32'({bus.alu_s, bus.alu_a, bus.alu_b}), 32'd0);
        chk("arst_rv",    32'(bus.res_valid), 32'd0);
        #1 rst_n = 1'b1;
        repeat (SETTLE + 1) begin
            step();
            chk("arst_norv", 32'(bus.res_valid), 32'd0);
            chk("arst_cnt",  32'(bus.txn_count), 32'd0);
        end

        // Directed operations
        do_txn(0, 4'b1110, 4'b0001, 0);
        do_txn(1, 4'b1010, 4'b0011, 0);
        do_txn(2, 4'b1010, 4'b0011, 0);
        do_txn(2, 4'b0011, 4'b0011, 0);
        do_txn(2, 4'b0001, 4'b1100, 0);
        do_txn(3, 4'b1010, 4'b0011, 6);
        do_txn(0, 4'b1111, 4'b1111, 0);
        do_txn(1, 4'b0010, 4'b0101, 1);

        // Back-to-back with req_valid held: one accept every PERIOD edges
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd3;
        bus.req_a     = 4'd10;
        bus.req_b     = 4'd3;
        for (int e = 0; e < 2 * PERIOD; e++) begin
            step();
            if (e == 0) begin
                bus.req_a = 4'd5;
                bus.req_b = 4'd12;
            end
            chk("b2b_busy", 32'(bus.busy), 32'((e % PERIOD) != PERIOD - 1));
            if (e == SETTLE)
                chk("b2b_data0", 32'(bus.res_data), 32'(m_data(3, 10, 3)));
            if (e == PERIOD)
                chk("b2b_a1", 32'(bus.alu_a), 32'd5);
            if (e == PERIOD + SETTLE)
                chk("b2b_data1", 32'(bus.res_data), 32'(m_data(3, 5, 12)));
            if ((e % PERIOD) == PERIOD - 1) begin
                exp_count = (exp_count + 1) % 256;
                chk("b2b_cnt", 32'(bus.txn_count), 32'(exp_count));
            end
        end
        bus.req_valid = 1'b0;

        // Counter wrap: restart from reset and run 257 random transactions
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        exp_count = 0;
        step();
        chk("wrap_start", 32'(bus.txn_count), 32'd0);
        for (int t = 1; t <= 257; t++) begin
            do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
            if (t == 256) chk("wrap_256", 32'(bus.txn_count), 32'd0);
            if (t == 257) chk("wrap_257", 32'(bus.txn_count), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Registered transaction front-end for the combinational 4-bit ALU. Accepts one operation request (select, A, B) over a valid/ready handshake and drives the ALU's S/A/B inputs from registers. Waits a fixed settle interval, then captures the selected ALU result into a registered response returned over a second valid/ready handshake. It is the initiator on the ALU's input/output interface and replaces bench-style timed stimulus with a clocked protocol.

## Interface

Parameters:
- SETTLE_CYCLES, default 2, clock edges between operand launch and result capture; legal range 1–15.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; equals (state == IDLE).
- req_op  in  2  operation select: 00 add, 01 sub, 10 compare, 11 AND.
- req_a  in  4  operand A.
- req_b  in  4  operand B.
- alu_s  out  2  registered select to ALU S.
- alu_a  out  4  registered operand to ALU A.
- alu_b  out  4  registered operand to ALU B.
- y_add, y_sub, y_and  in  4 each  ALU results.
- carry_add, carry_sub  in  1 each  ALU carries.
- agb, aeb, alb  in  1 each  ALU compare flags.
- res_valid  out  1  response present.
- res_ready  in  1  consumer accepts response.
- res_op  out  2  op of this response.
- res_data  out  4  result value.
- res_carry  out  1  result carry.
- res_flags  out  3  {agb, aeb, alb}.
- busy  out  1  state != IDLE.
- txn_count  out  8  completed responses, wraps modulo 256.

## Operation

- States: IDLE, SETTLE, RESP. Reset enters IDLE.
- IDLE: req_ready=1. On an edge with req_valid=1, load alu_s/alu_a/alu_b from req_op/req_a/req_b, clear the settle counter, and go to SETTLE. req_valid=0 keeps the state in IDLE.
- SETTLE: req_ready=0. Counter increments each edge. On the edge where counter == SETTLE_CYCLES-1, capture the result and go to RESP.
- Capture mapping, selected by alu_s:
  - 00: data=y_add, carry=carry_add, flags=000.
  - 01: data=y_sub, carry=carry_sub, flags=000.
  - 10: data=0000, carry=0, flags={agb,aeb,alb}.
  - 11: data=y_and, carry=0, flags=000.
  - res_op takes alu_s.
- RESP: res_valid=1. All res_* outputs are held stable until handshake. On an edge with res_ready=1: res_valid clears, txn_count increments (255→0), and the state returns to IDLE.
- alu_s/alu_a/alu_b hold the last launched operands between transactions; they are never cleared except by reset.
- No request is accepted in SETTLE or RESP. req_* inputs are ignored there.

## Timing

- Reset (rst_n low, asynchronous): state=IDLE, counter=0, alu_s/alu_a/alu_b=0, res_valid=0, res_op/res_data/res_carry/res_flags=0, txn_count=0, busy=0, req_ready=1.
- Reset asserted mid-SETTLE or mid-RESP aborts the transaction: no response and no count increment.
- Request accepted at edge k: alu_* valid after edge k, res_valid high after edge k+SETTLE_CYCLES.
- Response handshake at edge m: req_ready high after edge m. The earliest next accept is edge m+1.
- Minimum period per transaction is SETTLE_CYCLES+2 edges, given zero backpressure and req_valid continuously high.
- res_ready held low stalls indefinitely, with res_* stable and busy=1.
- res_ready asserted while res_valid=0 has no effect.

## Test plan

Bench uses a behavioural ALU model: sub is computed as A+~B+1, and carry_sub is its carry-out. SETTLE_CYCLES=2, res_ready=1 unless noted.

- Add, op=00, A=1110, B=0001, accepted at edge 0: res_valid after edge 2, res_data=1111, res_carry=0, res_flags=000, txn_count 0→1 after edge 3.
- Sub, op=01, A=1010, B=0011: res_data=0111, res_carry=1, res_op=01. Compare, op=10, same operands: res_data=0000, res_flags=100. Swap to A=0011, B=0011: res_flags=010.
- AND, op=11, A=1010, B=0011: res_data=0010, res_carry=0. Back-to-back requests with req_valid held high are accepted every 4 edges.
- Backpressure: hold res_ready=0 for 6 cycles after res_valid. Required: res_* unchanged, req_ready=0, busy=1, and a new request is not accepted. Release res_ready: handshake, then IDLE.
- Reset mid-SETTLE, pulsed asynchronously between edges: all outputs return to reset values immediately and txn_count stays 0. The next request completes normally.
- Run 257 transactions: txn_count wraps to 0 after the 256th handshake and reads 1 after the 257th.
